ex_div_ctrl: RTL and testbench

Multi-cycle sequencer for integer division in the EX stage. Accepts DIV/DIVU requests from the decoder and runs a 32-iteration radix-2 restoring-division datapath. Holds the pipeline through a stall request and delivers quotient/remainder as LO/HI with a one-cycle done pulse. Sits beside the single-cycle logic/shift unit and shares its operand buses.

---
 rtl/ex_div_ctrl.sv | 147 ++++++++++++++
 tb/tb_ex_div_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle radix-2 restoring divider sequencer for EX (DIV/DIVU).
// Ports: clk, rst_n (async low), start, is_signed, flush, operand_1 (dividend),
//   operand_2 (divisor) -> stall_req (comb), busy, done (1-cycle pulse),
//   lo (quotient), hi (remainder).
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module ex_div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic              flush,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic              div_zero;
    logic              early;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quot_n;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign accept   = start & ~flush & (state == IDLE || state == DONE);
    assign div_zero = (operand_2 == '0);

    assign mag1 = (is_signed && operand_1[DATA_W-1]) ? -operand_1 : operand_1;
    assign mag2 = (is_signed && operand_2[DATA_W-1]) ? -operand_2 : operand_2;

`ifdef DIV_EARLY_OUT_EN
    assign early = ~div_zero & (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    // Only a divide that will actually enter RUN holds the pipeline.
    assign stall_req = (accept & ~div_zero & ~early) | (state == RUN);

    // One restoring step: the shifted partial remainder needs DATA_W+1 bits,
    // and the trial sign bit decides whether to keep the subtraction.
    assign shifted = {rem, quot[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvsr};
    assign rem_n   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quot_n  = {quot[DATA_W-2:0], ~trial[DATA_W]};
    assign q_fix   = neg_q ? -quot_n : quot_n;
    assign r_fix   = neg_r ? -rem_n : rem_n;

    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) state_d = (div_zero | early) ? DONE : RUN;
                    else state_d = IDLE;
                end
                RUN: begin
                    if (cnt == LAST) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            quot  <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lo    <= '0;
            hi    <= '0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                if (div_zero) begin
                    lo <= '1;
                    hi <= operand_1;
                end else if (early) begin
                    lo <= '0;
                    hi <= operand_1;
                end else begin
                    cnt   <= '0;
                    rem   <= '0;
                    quot  <= mag1;
                    dvsr  <= mag2;
                    neg_q <= is_signed & (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
                    neg_r <= is_signed & operand_1[DATA_W-1];
                end
            end else if (state == RUN) begin
                rem  <= rem_n;
                quot <= quot_n;
                cnt  <= cnt + 1'b1;
                if (cnt == LAST) begin
                    lo <= q_fix;
                    hi <= r_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: scoreboard bench for ex_div_ctrl; directed divides with
// hand-computed quotient/remainder/latency, plus flush, reset and back-to-back cases.
module tb_ex_div_ctrl;

    localparam int W = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
    localparam int EO_STL = 0;
`else
    localparam int EO_LAT = 33;
    localparam int EO_STL = 31;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic         stall_req;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    ex_div_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .lo        (lo),
        .hi        (hi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: got done=1 at cycle %0d want 0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lo", lo, e.lo);
                chk("hi", hi, e.hi);
                chk("done_cycle", W'(cyc), W'(e.at));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input int lat, input bit push);
        exp_t e;
        operand_1 = a;
        operand_2 = b;
        is_signed = s;
        start = 1'b1;
        #1;
        chk("stall_at_start", W'(stall_req), W'(lat > 1));
        if (push) begin
            e.lo = elo;
            e.hi = ehi;
            e.at = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_stall);
        int sc;
        bit ok;
        sc = 0;
        ok = 1'b0;
        #2;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
            if (stall_req) sc++;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done want done within 40 cycles", name);
            sb.delete();
        end
        chk({name, "_stall_cycles"}, W'(sc), W'(exp_stall));
    endtask

    initial begin
        #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_lo", lo, '0);
        chk("rst_hi", hi, '0);
        chk("rst_stall", W'(stall_req), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b1);
        wait_done("divu_100_7", 31);
        issue(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b1);
        wait_done("div_m100_7", 31);
        issue(32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 33, 1'b1);
        wait_done("div_100_m7", 31);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 33, 1'b1);
        wait_done("div_ovf", 31);
        issue(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1, 1'b1);
        wait_done("divu_5_0", 0);
        issue(32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 1'b1);
        wait_done("div_m5_0", 0);
        issue(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, EO_LAT, 1'b1);
        wait_done("divu_3_10", EO_STL);
        issue(32'hFFFFFFFD, 32'd10, 1'b1, 32'd0, 32'hFFFFFFFD, EO_LAT, 1'b1);
        wait_done("div_m3_10", EO_STL);

        // second start lands in the DONE cycle; a mid-RUN start is ignored
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b1);
        wait_done("b2b_first", 31);
        issue(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 33, 1'b1);
        repeat (10) @(negedge clk);
        operand_1 = 32'd1;
        operand_2 = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", 20);

        // flush in cycle 10 of a divide
        issue(32'd100, 32'd7, 1'b0, '0, '0, 33, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", W'(busy), '0);
        chk("flush_stall", W'(stall_req), '0);
        chk("flush_lo", lo, 32'd6);
        chk("flush_hi", hi, 32'd2);
        repeat (30) @(negedge clk);

        // flush and start together: flush wins
        operand_1 = 32'd100;
        operand_2 = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_start_stall", W'(stall_req), '0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_start_busy", W'(busy), '0);
        repeat (35) @(negedge clk);

        // reset in cycle 10 of a divide
        issue(32'd100, 32'd7, 1'b0, '0, '0, 33, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", W'(busy), '0);
        chk("mid_rst_done", W'(done), '0);
        chk("mid_rst_lo", lo, '0);
        chk("mid_rst_hi", hi, '0);
        chk("mid_rst_stall", W'(stall_req), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (35) @(negedge clk);

        issue(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 33, 1'b1);
        wait_done("after_rst", 31);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
